// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Z = X - Y - B_in, LSB first, one full-subtractor cell plus a borrow flop.
// Optional signed-overflow output V is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             B_in,
    output logic [WIDTH-1:0] Z,
    output logic             B_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             V
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [WIDTH-2:0] r_rs;
    logic             r_b;
    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_b_next;
    logic [WIDTH-1:0] w_res;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_xmsb;
    logic             r_ymsb;
`endif

    // Full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] fsub(input logic a, input logic bb, input logic bi);
        return {(~a & bb) | (~(a ^ bb) & bi), a ^ bb ^ bi};
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign {w_b_next, w_d} = fsub(r_xs[0], r_ys[0], r_b);
    assign w_res           = {w_d, r_rs};
    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_xs  <= '0;
            r_ys  <= '0;
            r_rs  <= '0;
            r_b   <= 1'b0;
            Z     <= '0;
            B_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_xmsb <= 1'b0;
            r_ymsb <= 1'b0;
            V      <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_xs  <= X;
            r_ys  <= Y;
            r_rs  <= '0;
            r_b   <= B_in;
`ifdef SERIAL_SUB_OVF_EN
            r_xmsb <= X[WIDTH-1];
            r_ymsb <= Y[WIDTH-1];
`endif
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CW'(1);
            r_xs  <= r_xs >> 1;
            r_ys  <= r_ys >> 1;
            r_rs  <= w_res[WIDTH-1:1];
            r_b   <= w_b_next;
            // Outputs change only on the completion edge so partial results never show.
            if (w_last) begin
                Z     <= w_res;
                B_out <= w_b_next;
`ifdef SERIAL_SUB_OVF_EN
                V     <= (r_xmsb != r_ymsb) & (w_d != r_xmsb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=4.
// Overflow checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    logic       CLK = 1'b0;
    logic       RST;
    logic       start;
    logic [3:0] X;
    logic [3:0] Y;
    logic       B_in;
    logic [3:0] Z;
    logic       B_out;
    logic       busy;
    logic       done;
`ifdef SERIAL_SUB_OVF_EN
    logic       V;
`endif

    int checks   = 0;
    int failures = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .start (start),
        .X     (X),
        .Y     (Y),
        .B_in  (B_in),
        .Z     (Z),
        .B_out (B_out),
        .busy  (busy),
        .done  (done)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .V     (V)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pulse start for one edge, then wait (bounded) for done; lat = edges after the accepting one.
    task automatic do_op(input logic [3:0] x, input logic [3:0] y, input logic bin,
                         output int lat, output bit ok);
        X = x; Y = y; B_in = bin; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b0; X = 4'hA; Y = 4'h5; B_in = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        checks++;
        if (Z !== 4'h0 || B_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: Z=%h B_out=%b busy=%b done=%b, want 0 0 0 0", Z, B_out, busy, done);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (V !== 1'b0) begin
            failures++;
            $display("FAIL reset_V: got %b want 0", V);
        end
`endif
    endtask

    task automatic test_basic();
        int n;
        int nb;
        X = 4'd4; Y = 4'd2; B_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            tick();
            n++;
        end
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 4", n);
        end
        checks++;
        if (nb !== 4) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d want 4", nb);
        end
        checks++;
        if (Z !== 4'b0010 || B_out !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: Z=%b B_out=%b busy=%b, want 0010 0 0", Z, B_out, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Z !== 4'b0010) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b busy=%b Z=%b, want 0 0 0010", done, busy, Z);
        end
    endtask

    task automatic test_borrow();
        logic [3:0] xv [4] = '{4'd2, 4'd0, 4'd15, 4'd15};
        logic [3:0] yv [4] = '{4'd4, 4'd0, 4'd15, 4'd0};
        logic       bv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] ez [4] = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(xv[i], yv[i], bv[i], lat, ok);
            checks++;
            if (!ok || Z !== ez[i] || B_out !== eb[i]) begin
                failures++;
                $display("FAIL borrow_vec%0d: done=%b Z=%b B_out=%b, want 1 %b %b", i, ok, Z, B_out, ez[i], eb[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int t1;
        X = 4'd9; Y = 4'd3; B_in = 1'b0; start = 1'b1;
        tick();
        t = 0;
        tick();
        t++;
        X = 4'd1;
        while (!done && t < 20) begin
            tick();
            t++;
        end
        t1 = t;
        checks++;
        if (done !== 1'b1 || t1 !== 4 || Z !== 4'b0110 || B_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: done=%b t=%0d Z=%b B_out=%b, want 1 4 0110 0", done, t1, Z, B_out);
        end
        tick();
        t++;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_reaccept: done=%b busy=%b, want 0 1", done, busy);
        end
        while (!done && t < 40) begin
            tick();
            t++;
        end
        checks++;
        if (done !== 1'b1 || (t - t1) !== 5 || Z !== 4'b1110 || B_out !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: done=%b period=%0d Z=%b B_out=%b, want 1 5 1110 1", done, t - t1, Z, B_out);
        end
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_start_ignored();
        int ndone;
        logic [3:0] zc;
        logic       bc;
        X = 4'd5; Y = 4'd1; B_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        X = 4'd2; Y = 4'd7; B_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; zc = 4'hx; bc = 1'bx;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                ndone++;
                zc = Z;
                bc = B_out;
            end
            tick();
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_done_count: got %0d want 1", ndone);
        end
        checks++;
        if (zc !== 4'b0100 || bc !== 1'b0) begin
            failures++;
            $display("FAIL ignore_result: Z=%b B_out=%b, want 0100 0", zc, bc);
        end
    endtask

    task automatic test_reset_midrun();
        int lat;
        bit ok;
        int ndone;
        do_op(4'd0, 4'd1, 1'b0, lat, ok);
        checks++;
        if (!ok || Z !== 4'b1111 || B_out !== 1'b1) begin
            failures++;
            $display("FAIL prerst_result: done=%b Z=%b B_out=%b, want 1 1111 1", ok, Z, B_out);
        end
        tick();
        X = 4'd2; Y = 4'd4; B_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (Z !== 4'h0 || B_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midrun_reset: Z=%b B_out=%b busy=%b done=%b, want 0000 0 0 0", Z, B_out, busy, done);
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL midrun_no_done: active cycles=%0d want 0", ndone);
        end
        do_op(4'd7, 4'd2, 1'b1, lat, ok);
        checks++;
        if (!ok || lat !== 4 || Z !== 4'b0100 || B_out !== 1'b0) begin
            failures++;
            $display("FAIL postrst_result: done=%b lat=%0d Z=%b B_out=%b, want 1 4 0100 0", ok, lat, Z, B_out);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [3:0] xv [3] = '{4'b0111, 4'b0101, 4'b1000};
        logic [3:0] yv [3] = '{4'b1000, 4'b0011, 4'b0001};
        logic [3:0] ez [3] = '{4'b1111, 4'b0010, 4'b0111};
        logic       eb [3] = '{1'b1, 1'b0, 1'b0};
        logic       ev [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            do_op(xv[i], yv[i], 1'b0, lat, ok);
            checks++;
            if (!ok || Z !== ez[i] || B_out !== eb[i]) begin
                failures++;
                $display("FAIL ovf_vec%0d: done=%b Z=%b B_out=%b, want 1 %b %b", i, ok, Z, B_out, ez[i], eb[i]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (V !== ev[i]) begin
                failures++;
                $display("FAIL ovf_V%0d: got %b want %b", i, V, ev[i]);
            end
`else
            if (ev[i] === 1'bx) $display("unexpected");
`endif
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_start_ignored();
        test_reset_midrun();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
